// File: rtl/ntt_tf_sched_if.sv
// Handshake and ROM-side bundle between the NTT controller and the twiddle read scheduler.
// The controller drives start/stall; the scheduler drives everything else.
interface ntt_tf_sched_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic              tf_valid;
  logic [1:0]        tf_stage;
  logic              tf_stage_last;
  logic              busy;
  logic              done;

  modport master (
    output start, stall,
    input  rom_addr, rom_en, tf_valid, tf_stage, tf_stage_last, busy, done
  );

  modport slave (
    input  start, stall,
    output rom_addr, rom_en, tf_valid, tf_stage, tf_stage_last, busy, done
  );
endinterface

// File: rtl/ntt_tf_sched.sv
// Twiddle ROM read scheduler: sweeps three ROM segments a fixed number of times each and
// tags the ROM output (1-cycle latency) with valid, stage index and end-of-stage markers.
module ntt_tf_sched #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 108,
  parameter int S0_LEN = 4,
  parameter int S0_REP = 16,
  parameter int S1_LEN = 32,
  parameter int S1_REP = 2,
  parameter int S2_LEN = 64,
  parameter int S2_REP = 1
) (
  input  logic           clk,
  input  logic           rst,
  ntt_tf_sched_if.slave  bus
);

  localparam int REP_W = $clog2(S0_REP + S1_REP + S2_REP + 1);
  localparam logic [ADDR_W-1:0] B1 = ADDR_W'(S0_LEN);
  localparam logic [ADDR_W-1:0] B2 = ADDR_W'(S0_LEN + S1_LEN);

  if (S0_LEN + S1_LEN + S2_LEN > DEPTH) begin : g_depth_check
    $error("ntt_tf_sched: segments do not fit in the ROM");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        stage_q;
  logic [ADDR_W-1:0] idx_q;
  logic [REP_W-1:0]  rep_q;
  logic [ADDR_W-1:0] addr_q;
  logic              en_q;
  logic              valid_q;
  logic [1:0]        tag_stage_q;
  logic              tag_last_q;
  logic              done_q;

  logic [ADDR_W-1:0] idx_max;
  logic [REP_W-1:0]  rep_max;
  logic [ADDR_W-1:0] base_cur;
  logic [ADDR_W-1:0] base_next;
  logic              idx_end;
  logic              seg_end;
  logic              run_end;

  // Per-stage segment geometry, selected by the current stage counter.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idx_max   = ADDR_W'(S2_LEN - 1);
    rep_max   = REP_W'(S2_REP - 1);
    base_cur  = B2;
    base_next = B2;
    case (stage_q)
      2'd0: begin
        idx_max   = ADDR_W'(S0_LEN - 1);
        rep_max   = REP_W'(S0_REP - 1);
        base_cur  = '0;
        base_next = B1;
      end
      2'd1: begin
        idx_max   = ADDR_W'(S1_LEN - 1);
        rep_max   = REP_W'(S1_REP - 1);
        base_cur  = B1;
        base_next = B2;
      end
      default: ;
    endcase
    idx_end = (idx_q == idx_max);
    seg_end = idx_end && (rep_q == rep_max);
    run_end = seg_end && (stage_q == 2'd2);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (en_q && run_end) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Counters always describe rom_addr; a stall simply withholds rom_en for the pending address.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      idx_q       <= '0;
      rep_q       <= '0;
      addr_q      <= '0;
      en_q        <= 1'b0;
      valid_q     <= 1'b0;
      tag_stage_q <= '0;
      tag_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      valid_q     <= en_q;
      tag_stage_q <= en_q ? stage_q : 2'd0;
      tag_last_q  <= en_q && seg_end;
      done_q      <= en_q && run_end;

      case (state_q)
        IDLE: begin
          en_q <= bus.start;
          if (bus.start) begin
            stage_q <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            addr_q  <= '0;
          end
        end
        RUN: begin
          if (!en_q) begin
            en_q <= !bus.stall;
          end else if (run_end) begin
            en_q <= 1'b0;
          end else begin
            en_q <= !bus.stall;
            if (!idx_end) begin
              idx_q  <= idx_q + ADDR_W'(1);
              addr_q <= addr_q + ADDR_W'(1);
            end else if (!seg_end) begin
              idx_q  <= '0;
              rep_q  <= rep_q + REP_W'(1);
              addr_q <= base_cur;
            end else begin
              idx_q   <= '0;
              rep_q   <= '0;
              stage_q <= stage_q + 2'd1;
              addr_q  <= base_next;
            end
          end
        end
        default: en_q <= 1'b0;
      endcase
    end
  end

  assign bus.rom_addr      = addr_q;
  assign bus.rom_en        = en_q;
  assign bus.tf_valid      = valid_q;
  assign bus.tf_stage      = tag_stage_q;
  assign bus.tf_stage_last = tag_last_q;
  assign bus.done          = done_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ntt_tf_sched.sv
// Scoreboard bench for ntt_tf_sched: each accepted start queues the full expected read
// sequence; a negedge monitor pops and compares issued addresses and tagged ROM words.
module tb_ntt_tf_sched;

  localparam int ADDR_W = 7;
  localparam int S0_LEN = 4;
  localparam int S0_REP = 16;
  localparam int S1_LEN = 32;
  localparam int S1_REP = 2;
  localparam int S2_LEN = 64;
  localparam int S2_REP = 1;
  localparam int N = S0_LEN * S0_REP + S1_LEN * S1_REP + S2_LEN * S2_REP;

  typedef struct {
    int addr;
    int stage;
    bit last;
    bit fin;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   first_pending = 1'b0;
  int   first_en_cyc = -1;
  word_t issue_q[$];
  word_t tag_q[$];

  ntt_tf_sched_if #(.ADDR_W(ADDR_W)) bus ();

  ntt_tf_sched #(
    .ADDR_W(ADDR_W), .DEPTH(108),
    .S0_LEN(S0_LEN), .S0_REP(S0_REP),
    .S1_LEN(S1_LEN), .S1_REP(S1_REP),
    .S2_LEN(S2_LEN), .S2_REP(S2_REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference sequence: every sweep of every segment, in order.
  task automatic push_run();
    int base;
    int len;
    int rep;
    word_t w;
    base = 0;
    for (int s = 0; s < 3; s++) begin
      len = (s == 0) ? S0_LEN : (s == 1) ? S1_LEN : S2_LEN;
      rep = (s == 0) ? S0_REP : (s == 1) ? S1_REP : S2_REP;
      for (int r = 0; r < rep; r++) begin
        for (int i = 0; i < len; i++) begin
          w.addr  = base + i;
          w.stage = s;
          w.last  = (r == rep - 1) && (i == len - 1);
          w.fin   = w.last && (s == 2);
          issue_q.push_back(w);
          tag_q.push_back(w);
        end
      end
      base += len;
    end
  endtask

  always @(negedge clk) begin : monitor
    word_t w;
    if (!rst) begin
      if (bus.rom_en) begin
        if (first_pending) begin
          first_en_cyc  = cyc;
          first_pending = 1'b0;
        end
        check("issue_expected", int'(issue_q.size() > 0), 1);
        if (issue_q.size() > 0) begin
          w = issue_q.pop_front();
          check("issue_addr", int'(bus.rom_addr), w.addr);
        end
      end
      if (bus.tf_valid) begin
        check("valid_expected", int'(tag_q.size() > 0), 1);
        if (tag_q.size() > 0) begin
          w = tag_q.pop_front();
          check("tf_stage", int'(bus.tf_stage), w.stage);
          check("tf_stage_last", int'(bus.tf_stage_last), int'(w.last));
          check("done_on_final", int'(bus.done), int'(w.fin));
        end
      end else begin
        check("done_without_valid", int'(bus.done), 0);
      end
    end
  end

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic launch();
    bus.start     = 1'b1;
    first_pending = 1'b1;
    push_run();
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(bus.done), 1);
    dc = cyc;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rom_en"}, int'(bus.rom_en), 0);
    check({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    check({tag, "_tf_valid"}, int'(bus.tf_valid), 0);
    check({tag, "_tf_stage"}, int'(bus.tf_stage), 0);
    check({tag, "_tf_stage_last"}, int'(bus.tf_stage_last), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin : stimulus
    int c0;
    int dc;
    int nst;
    bus.start = 1'b0;
    bus.stall = 1'b0;

    go_to(2);
    check_idle_outputs("reset");
    go_to(3);
    rst = 1'b0;

    // Plain run from cycle 10; stall while idle must be ignored.
    go_to(7);
    bus.stall = 1'b1;
    go_to(10);
    bus.stall = 1'b0;
    launch();
    check("s1_busy_first", int'(bus.busy), 1);
    wait_done(400, dc);
    check("s1_first_en", first_en_cyc, 11);
    check("s1_done_cycle", dc, 203);
    check("s1_busy_at_done", int'(bus.busy), 1);
    @(negedge clk);
    check("s1_busy_after", int'(bus.busy), 0);
    check("s1_valid_after", int'(bus.tf_valid), 0);
    check("s1_queue_empty", issue_q.size() + tag_q.size(), 0);

    // Second start mid-run is ignored.
    go_to(cyc + 3);
    c0 = cyc;
    launch();
    go_to(c0 + 40);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(400, dc);
    check("s2_done_cycle", dc, c0 + N + 1);

    // Three-cycle stall that holds address 20.
    go_to(cyc + 2);
    c0 = cyc;
    launch();
    begin
      int n;
      n = 0;
      while (!(bus.rom_en && bus.rom_addr == 7'd19) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("s3_reached_19", int'(bus.rom_en && bus.rom_addr == 7'd19), 1);
    end
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) bus.stall = 1'b0;
      check("s3_stall_en", int'(bus.rom_en), 0);
      check("s3_stall_addr", int'(bus.rom_addr), 20);
    end
    @(negedge clk);
    check("s3_resume_en", int'(bus.rom_en), 1);
    check("s3_resume_addr", int'(bus.rom_addr), 20);
    wait_done(400, dc);
    check("s3_done_cycle", dc, c0 + N + 1 + 3);

    // Random stalls early in the run; idle stall around start has no effect.
    for (int run = 0; run < 3; run++) begin
      c0 = cyc + 3 + int'($urandom_range(0, 4));
      go_to(c0 - 2);
      bus.stall = 1'b1;
      go_to(c0);
      launch();
      nst = 0;
      for (int k = 1; k <= 150; k++) begin
        bus.stall = ($urandom_range(0, 2) == 0);
        nst += int'(bus.stall);
        @(negedge clk);
      end
      bus.stall = 1'b0;
      wait_done(600, dc);
      check("rand_done_cycle", dc, c0 + N + 1 + nst);
    end

    // Reset mid-run aborts; restart from address 0.
    go_to(cyc + 2);
    c0 = cyc;
    launch();
    go_to(c0 + 90);
    rst = 1'b1;
    @(negedge clk);
    issue_q.delete();
    tag_q.delete();
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    go_to(c0 + 100);
    launch();
    wait_done(400, dc);
    check("s5_first_en", first_en_cyc, c0 + 101);
    check("s5_done_cycle", dc, c0 + 100 + N + 1);

    // Back-to-back: start in the cycle right after done.
    @(negedge clk);
    c0 = cyc;
    launch();
    wait_done(400, dc);
    check("s6_first_en", first_en_cyc, c0 + 1);
    check("s6_done_cycle", dc, c0 + N + 1);

    go_to(cyc + 3);
    check("final_queue_empty", issue_q.size() + tag_q.size(), 0);
    check("final_busy", int'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
